// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer with a built-in prescaler.
// Drives four active-low seven-segment digits and flags when the count reaches 0000.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic        Clkin,
    input  logic        clear,
    input  logic [15:0] load_val,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    output logic [6:0]  num0,
    output logic [6:0]  num1,
    output logic [6:0]  num2,
    output logic [6:0]  num3,
    output logic        running,
    output logic        done,
    output logic        tick
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [15:0]      count_q, count_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;

    // Digits above 9 are clamped to 9.
    function automatic logic [15:0] sanitise(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clkin or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            count_q <= 16'h0000;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    count_d = sanitise(load_val);
                end else if (start && count_q != 16'h0000) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                if (pause) begin
                    state_d = S_PAUSED;
                end else if (count_q == 16'h0000) begin
                    state_d = S_DONE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    count_d = bcd_dec(count_q);
                    if (count_d == 16'h0000) state_d = S_DONE;
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            S_PAUSED: begin
                if (load) begin
                    count_d = sanitise(load_val);
                    presc_d = '0;
                end else if (start && !pause && count_q != 16'h0000) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (load) begin
                    count_d = sanitise(load_val);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        tick    = tick_q;
        num0    = seg7(count_q[3:0]);
        num1    = seg7(count_q[7:4]);
        num2    = seg7(count_q[11:8]);
        num3    = seg7(count_q[15:12]);
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with TICK_DIV=4.
// Expected display/flag vectors are queued as stimulus is applied and compared after the clock edge.
module tb_bcd_countdown_timer;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;

    logic        Clkin = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [6:0]  num0, num1, num2, num3;
    logic        running, done, tick;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [30:0] v;
    } exp_t;
    exp_t sb_q[$];

    bcd_countdown_timer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .Clkin(Clkin), .clear(clear), .load_val(load_val), .load(load),
        .start(start), .pause(pause), .num0(num0), .num1(num1), .num2(num2),
        .num3(num3), .running(running), .done(done), .tick(tick)
    );

    always #5 Clkin = ~Clkin;

    wire [30:0] obs = {num3, num2, num1, num0, running, done, tick};

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] t[10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic logic [30:0] ev(input logic [15:0] c, input logic r, input logic dn, input logic t);
        return {seg(c[15:12]), seg(c[11:8]), seg(c[7:4]), seg(c[3:0]), r, dn, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic [30:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, {1'b0, obs}, {1'b0, e.v});
        end
    endtask

    task automatic step();
        @(posedge Clkin);
        #1;
    endtask

    // Steps until tick is seen or the bound expires; returns cycles taken.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 4 * TICK_DIV);
    endtask

    int n;

    initial begin
        // Power-on reset
        #2;
        push("por", ev(16'h0000, 0, 0, 0));
        pop_check();
        step();
        clear = 1'b1;

        // Reset mid-run with count 0042
        load_val = 16'h0042; load = 1'b1;
        push("load_42", ev(16'h0042, 0, 0, 0));
        step(); load = 1'b0; pop_check();
        start = 1'b1;
        push("run_42", ev(16'h0042, 1, 0, 0));
        step(); start = 1'b0; pop_check();
        step(); step();
        clear = 1'b0; #1;
        push("clear_mid", ev(16'h0000, 0, 0, 0));
        pop_check();
        #1 clear = 1'b1;
        push("after_clear", ev(16'h0000, 0, 0, 0));
        step(); pop_check();

        // Load 0003 and run to DONE
        load_val = 16'h0003; load = 1'b1;
        push("load_3", ev(16'h0003, 0, 0, 0));
        step(); load = 1'b0; pop_check();
        start = 1'b1;
        push("start_3", ev(16'h0003, 1, 0, 0));
        step(); start = 1'b0; pop_check();
        for (int k = 2; k >= 0; k--) begin
            push($sformatf("tick_%0d", k), ev(16'(k), k != 0, k == 0, 1'b1));
            wait_tick(n);
            check("tick_gap", 32'(n), 32'(TICK_DIV));
            pop_check();
        end
        for (int i = 0; i < 6; i++) begin
            push("done_hold", ev(16'h0000, 0, 1, 0));
            step(); pop_check();
        end

        // Borrow chain 1000 -> 0999 (load accepted from DONE)
        load_val = 16'h1000; load = 1'b1;
        push("load_1000", ev(16'h1000, 0, 0, 0));
        step(); load = 1'b0; pop_check();
        start = 1'b1;
        push("start_1000", ev(16'h1000, 1, 0, 0));
        step(); start = 1'b0; pop_check();
        push("borrow", ev(16'h0999, 1, 0, 1));
        wait_tick(n);
        check("borrow_gap", 32'(n), 32'(TICK_DIV));
        pop_check();

        // load ignored in RUN, accepted (sanitised) in PAUSED
        step();
        load_val = 16'hFFFF; load = 1'b1;
        push("load_in_run", ev(16'h0999, 1, 0, 0));
        step(); load = 1'b0; pop_check();
        pause = 1'b1;
        push("pause_0999", ev(16'h0999, 0, 0, 0));
        step(); pop_check();
        load = 1'b1;
        push("load_ffff_paused", ev(16'h9999, 0, 0, 0));
        step(); load = 1'b0; pop_check();
        pause = 1'b0; start = 1'b1;
        push("resume_9999", ev(16'h9999, 1, 0, 0));
        step(); start = 1'b0; pop_check();
        push("tick_9998", ev(16'h9998, 1, 0, 1));
        wait_tick(n);
        check("presc_cleared_gap", 32'(n), 32'(TICK_DIV));
        pop_check();
        clear = 1'b0; #1;
        push("clear_2", ev(16'h0000, 0, 0, 0));
        pop_check();
        #1 clear = 1'b1;

        // Sanitise in IDLE, start with zero count ignored
        load_val = 16'h1AF3; load = 1'b1;
        push("load_1af3", ev(16'h1993, 0, 0, 0));
        step(); load = 1'b0; pop_check();
        load_val = 16'h0000; load = 1'b1;
        push("load_0", ev(16'h0000, 0, 0, 0));
        step(); load = 1'b0; pop_check();
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("start_zero", ev(16'h0000, 0, 0, 0));
            step(); pop_check();
        end
        start = 1'b0;

        // Pause at prescaler = 2 for 10 cycles
        load_val = 16'h0005; load = 1'b1;
        push("load_5", ev(16'h0005, 0, 0, 0));
        step(); load = 1'b0; pop_check();
        start = 1'b1;
        push("start_5", ev(16'h0005, 1, 0, 0));
        step(); start = 1'b0; pop_check();
        step(); step();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push("paused", ev(16'h0005, 0, 0, 0));
            step(); pop_check();
        end
        pause = 1'b0; start = 1'b1;
        push("resume_5", ev(16'h0005, 1, 0, 0));
        step(); start = 1'b0; pop_check();
        push("tick_4", ev(16'h0004, 1, 0, 1));
        wait_tick(n);
        check("resume_gap", 32'(n), 32'd2);
        pop_check();
        for (int k = 3; k >= 0; k--) begin
            push($sformatf("run_down_%0d", k), ev(16'(k), k != 0, k == 0, 1'b1));
            wait_tick(n);
            check("run_down_gap", 32'(n), 32'(TICK_DIV));
            pop_check();
        end

        // DONE: start ignored, load returns to IDLE
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push("done_start", ev(16'h0000, 0, 1, 0));
            step(); pop_check();
        end
        start = 1'b0;
        load_val = 16'h0002; load = 1'b1;
        push("reload_2", ev(16'h0002, 0, 0, 0));
        step(); load = 1'b0; pop_check();

        // load wins over start in IDLE
        load_val = 16'h0007; load = 1'b1; start = 1'b1;
        push("load_over_start", ev(16'h0007, 0, 0, 0));
        step(); load = 1'b0; pop_check();
        push("start_7", ev(16'h0007, 1, 0, 0));
        step(); start = 1'b0; pop_check();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Four-digit BCD down-counter with a built-in 1 Hz prescaler. Drives four active-low seven-segment displays and flags when the count reaches zero.
- Complements the existing up-counting seconds display. Its value is preset from switches, and it counts down from that value to 0000.
- Sits directly under the lab top level. Clocked from CLOCK_50, with outputs wired straight to HEX0–HEX3 and LEDR.

Parameters:
- TICK_DIV, 50000000: Clkin cycles per count tick. Must be ≥ 2. Simulation uses 4.
- CNT_W, 26: prescaler width. Must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- Clkin  in  1  system clock; all state updates on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- load_val  in  16  preset value as four BCD digits; [3:0] is the ones digit, [15:12] is the thousands digit.
- load  in  1  level; copies load_val into the count (see the states in which it is accepted).
- start  in  1  level; begins or resumes counting.
- pause  in  1  level; halts counting.
- num0  out  7  active-low segments {g,f,e,d,c,b,a} for the ones digit.
- num1  out  7  tens digit, same encoding.
- num2  out  7  hundreds digit, same encoding.
- num3  out  7  thousands digit, same encoding.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- tick  out  1  one-cycle pulse on each decrement.

Behaviour:
- **Reset (clear=0, async):**
  - State goes to IDLE.
  - Count = 0000 and prescaler = 0.
  - running = 0, done = 0, tick = 0.
  - num0–num3 = 7'b1000000 (digit "0").
  - Reset takes effect immediately, mid-count included.
- **States:** IDLE, RUN, PAUSED, DONE.
- **IDLE:**
  - load=1 → count ← sanitised load_val; stays in IDLE.
  - Otherwise, start=1 with count ≠ 0000 → RUN, prescaler ← 0.
  - start with count = 0000 is ignored.
  - load takes priority over start in the same cycle.
- **RUN:**
  - Prescaler increments every cycle.
  - When prescaler = TICK_DIV-1, on the next edge:
    - prescaler ← 0;
    - tick = 1 for that cycle;
    - count ← count - 1 in BCD. A digit at 0 becomes 9 and borrows from the next digit, e.g. 1000 → 0999 and 0010 → 0009.
    - If the new count is 0000, go to DONE.
  - First tick comes TICK_DIV cycles after entering RUN from reset prescaler.
  - pause=1 → PAUSED. The prescaler value is held and no tick occurs that cycle, even if the prescaler is at its terminal value.
  - pause takes priority over start.
  - load is ignored in RUN.
- **PAUSED:**
  - Prescaler is frozen.
  - load=1 → count ← sanitised load_val, prescaler ← 0, stay in PAUSED.
  - Otherwise, start=1 and pause=0 with count ≠ 0 → RUN, resuming from the held prescaler value.
- **DONE:**
  - done = 1 and count holds 0000.
  - start is ignored.
  - load=1 → count ← sanitised load_val, go to IDLE.
- **Sanitising load_val:** any digit > 9 is loaded as 9. Example: 16'h1AF3 loads 1993.
- **Decode:** num outputs are registered-count combinational decodes, standard active-low encoding:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- **Timing:** tick, running and done are registered; no combinational path from inputs to outputs.
- **No wrap-around:** the count never goes below 0000.

Test Plan (TICK_DIV=4):
- **Reset value.** Assert clear=0 mid-run with count 0042 → next sample shows:
  - num0–num3 = 1000000, state IDLE;
  - running = 0, done = 0, tick = 0.
- **Load and run.** load_val=16'h0003, load for 1 cycle, then start → running = 1.
  - tick pulses every 4 cycles.
  - Displays step 3 → 2 → 1 → 0.
  - done = 1 on the cycle of the third decrement; no further ticks.
- **Borrow chain.** Load 1000, run one tick → count 0999.
  - num3 = 1000000, num2 = num1 = num0 = 0010000.
- **Pause.** Run 0005, assert pause at prescaler = 2 for 10 cycles, then start.
  - No tick while paused.
  - Next tick 2 cycles after resume; count goes to 0004.
- **Illegal input and priority:**
  - Load 16'hFFFF → displays 9999.
  - load=1 during RUN → count unchanged.
  - start with count 0000 in IDLE → remains IDLE.
- **Reload from DONE.** In DONE, start=1 → no change. load_val=0002 with load → IDLE with count 0002, done = 0.
